n101_ilm_bank_ram: RTL and testbench

- Parametrised next-generation ILM memory: word-interleaved multi-bank SRAM array behind a valid/ready command channel and a valid/ready response channel.
- Each bank has its own power FSM that drops the bank into light-sleep (ls) after an idle period and into shutdown (sd) on request. Wake-up stalls the command channel for a fixed number of cycles.
- Sits between the ILM bus slave and the physical SRAM macros, and replaces a single flat ILM RAM.

---
 rtl/n101_ilm_bank_ram_pkg.sv | 22 ++
 rtl/n101_gnrl_ram.sv | 43 ++++
 rtl/n101_ilm_ram_bank.sv | 128 ++++++++++++
 rtl/n101_ilm_bank_ram.sv | 109 ++++++++++
 tb/tb_n101_ilm_bank_ram.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/n101_ilm_bank_ram_pkg.sv
// Shared definitions for the banked ILM memory: default build parameters,
// bank power-state encoding and a helper for bank-select width.
package n101_ilm_bank_ram_pkg;

    localparam int N101_ILM_BANKS    = 2;
    localparam int N101_ILM_IDLE_CYC = 16;
    localparam int N101_ILM_WAKE_LS  = 1;
    localparam int N101_ILM_WAKE_SD  = 4;

    typedef enum logic [1:0] {
        BANK_ACT  = 2'd0,
        BANK_LS   = 2'd1,
        BANK_SD   = 2'd2,
        BANK_WAKE = 2'd3
    } bank_state_e;

    // Number of low address bits used to pick a bank (0 for a single bank).
    function automatic int bank_bits(input int banks);
        return (banks > 1) ? $clog2(banks) : 0;
    endfunction

endpackage

// File: rtl/n101_gnrl_ram.sv
// Generic single-port SRAM model with byte write enables and a registered
// read port. Power pins block any access while the macro is not fully awake.
module n101_gnrl_ram #(
    parameter int DW = 32,
    parameter int MW = DW / 8,
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          cs,
    input  logic          we,
    input  logic [MW-1:0] wem,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    input  logic          ls,
    input  logic          sd,
    input  logic          ds,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem_reg [0:(2**AW)-1];
    logic [DW-1:0] dout_reg;
    logic          access_en;

    assign access_en = cs && !(ls || sd || ds);

    // Byte-masked write; reads update the output register, writes leave it alone
    always_ff @(posedge clk) begin
        if (access_en) begin
            if (we) begin
                for (int i = 0; i < MW; i++) begin
                    if (wem[i]) begin
                        mem_reg[addr][i*8 +: 8] <= din[i*8 +: 8];
                    end
                end
            end else begin
                dout_reg <= mem_reg[addr];
            end
        end
    end

    assign dout = dout_reg;

endmodule

// File: rtl/n101_ilm_ram_bank.sv
// One ILM bank: power-state machine (ACT/LS/SD/WAKE) with idle and wake
// counters, driving the power pins of its SRAM macro.
module n101_ilm_ram_bank
    import n101_ilm_bank_ram_pkg::*;
#(
    parameter int DW       = 32,
    parameter int MW       = DW / 8,
    parameter int BAW      = 13,
    parameter int IDLE_CYC = 16,
    parameter int WAKE_LS  = 1,
    parameter int WAKE_SD  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cs,
    input  logic           we,
    input  logic [MW-1:0]  wem,
    input  logic [BAW-1:0] addr,
    input  logic [DW-1:0]  wdata,
    input  logic           sd_req,
    input  logic           cmd_hit,
    input  logic           busy,
    output logic [DW-1:0]  dout,
    output logic           bank_act,
    output logic           bank_sleep
);

    localparam int WMAX = (WAKE_LS > WAKE_SD) ? WAKE_LS : WAKE_SD;
    localparam int WCW  = $clog2(WMAX) + 1;
    localparam int IW   = (IDLE_CYC > 0) ? $clog2(IDLE_CYC + 1) : 1;

    localparam logic [IW-1:0]  IDLE_MAX = IW'(IDLE_CYC);
    localparam logic [WCW-1:0] LS_LOAD  = WCW'(WAKE_LS);
    localparam logic [WCW-1:0] SD_LOAD  = WCW'(WAKE_SD);
    localparam logic [WCW-1:0] WCNT_ONE = WCW'(1);

    bank_state_e    state_reg;
    logic [IW-1:0]  idle_cnt_reg;
    logic [WCW-1:0] wake_cnt_reg;
    logic           wake_first_reg;
    logic           wake_from_sd_reg;
    logic           ls_pin;
    logic           sd_pin;

    // Power FSM: auto light-sleep on idle, shutdown on request, timed wake-up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= BANK_ACT;
            idle_cnt_reg     <= '0;
            wake_cnt_reg     <= '0;
            wake_first_reg   <= 1'b0;
            wake_from_sd_reg <= 1'b0;
        end else begin
            case (state_reg)
                BANK_ACT: begin
                    if (sd_req && !busy) begin
                        state_reg    <= BANK_SD;
                        idle_cnt_reg <= '0;
                    end else if (cs) begin
                        idle_cnt_reg <= '0;
                    end else if ((IDLE_CYC != 0) && (idle_cnt_reg == IDLE_MAX) && !busy) begin
                        state_reg    <= BANK_LS;
                        idle_cnt_reg <= '0;
                    end else if (idle_cnt_reg != IDLE_MAX) begin
                        idle_cnt_reg <= idle_cnt_reg + 1'b1;
                    end
                end
                BANK_LS: begin
                    if (sd_req && !busy) begin
                        state_reg <= BANK_SD;
                    end else if (cmd_hit) begin
                        state_reg        <= (WAKE_LS == 0) ? BANK_ACT : BANK_WAKE;
                        wake_cnt_reg     <= LS_LOAD;
                        wake_first_reg   <= 1'b1;
                        wake_from_sd_reg <= 1'b0;
                    end
                end
                BANK_SD: begin
                    if (!sd_req) begin
                        state_reg        <= (WAKE_SD == 0) ? BANK_ACT : BANK_WAKE;
                        wake_cnt_reg     <= SD_LOAD;
                        wake_first_reg   <= 1'b1;
                        wake_from_sd_reg <= 1'b1;
                    end
                end
                BANK_WAKE: begin
                    wake_first_reg <= 1'b0;
                    if (sd_req) begin
                        state_reg <= BANK_SD;
                    end else if (wake_cnt_reg <= WCNT_ONE) begin
                        state_reg    <= BANK_ACT;
                        wake_cnt_reg <= '0;
                    end else begin
                        wake_cnt_reg <= wake_cnt_reg - 1'b1;
                    end
                end
                default: state_reg <= BANK_ACT;
            endcase
        end
    end

    // The pin of the state being left stays asserted for the first wake cycle
    assign ls_pin = (state_reg == BANK_LS) ||
                    ((state_reg == BANK_WAKE) && wake_first_reg && !wake_from_sd_reg);
    assign sd_pin = (state_reg == BANK_SD) ||
                    ((state_reg == BANK_WAKE) && wake_first_reg && wake_from_sd_reg);

    assign bank_act   = (state_reg == BANK_ACT);
    assign bank_sleep = (state_reg == BANK_LS) || (state_reg == BANK_SD);

    n101_gnrl_ram #(
        .DW (DW),
        .MW (MW),
        .AW (BAW)
    ) u_ram (
        .clk  (clk),
        .cs   (cs),
        .we   (we),
        .wem  (wem),
        .addr (addr),
        .din  (wdata),
        .ls   (ls_pin),
        .sd   (sd_pin),
        .ds   (1'b0),
        .dout (dout)
    );

endmodule

// File: rtl/n101_ilm_bank_ram.sv
// Word-interleaved multi-bank ILM RAM with valid/ready command and response
// channels. One response may be outstanding; reads return the bank's dout.
module n101_ilm_bank_ram
    import n101_ilm_bank_ram_pkg::*;
#(
    parameter int DW       = 32,
    parameter int MW       = DW / 8,
    parameter int AW       = 14,
    parameter int BANKS    = N101_ILM_BANKS,
    parameter int IDLE_CYC = N101_ILM_IDLE_CYC,
    parameter int WAKE_LS  = N101_ILM_WAKE_LS,
    parameter int WAKE_SD  = N101_ILM_WAKE_SD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [MW-1:0]    cmd_wem,
    input  logic [DW-1:0]    cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DW-1:0]    rsp_rdata,
    input  logic             sd_req,
    output logic [BANKS-1:0] bank_sleep
);

    localparam int BW  = bank_bits(BANKS);
    localparam int SW  = (BW > 0) ? BW : 1;
    localparam int BAW = AW - BW;

    logic [SW-1:0]    cmd_bank;
    logic [BAW-1:0]   bank_addr;
    logic [BANKS-1:0] bank_act_vec;
    logic [DW-1:0]    bank_dout [BANKS];
    logic             ready_en_reg;
    logic             rsp_valid_reg;
    logic             rsp_read_reg;
    logic [SW-1:0]    rsp_bank_reg;
    logic             rsp_stall;
    logic             cmd_acc;

    generate
        if (BW > 0) begin : g_bank_sel
            assign cmd_bank = cmd_addr[SW-1:0];
        end else begin : g_one_bank
            assign cmd_bank = '0;
        end
    endgenerate

    assign bank_addr = cmd_addr[AW-1:BW];
    assign rsp_stall = rsp_valid_reg && !rsp_ready;
    assign cmd_ready = ready_en_reg && bank_act_vec[cmd_bank] && !sd_req && !rsp_stall;
    assign cmd_acc   = cmd_valid && cmd_ready;

    generate
        for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
            logic hit;
            assign hit = cmd_valid && (cmd_bank == SW'(gi));

            n101_ilm_ram_bank #(
                .DW       (DW),
                .MW       (MW),
                .BAW      (BAW),
                .IDLE_CYC (IDLE_CYC),
                .WAKE_LS  (WAKE_LS),
                .WAKE_SD  (WAKE_SD)
            ) u_bank (
                .clk        (clk),
                .rst_n      (rst_n),
                .cs         (cmd_acc && hit),
                .we         (cmd_we),
                .wem        (cmd_wem),
                .addr       (bank_addr),
                .wdata      (cmd_wdata),
                .sd_req     (sd_req),
                .cmd_hit    (hit),
                .busy       (rsp_valid_reg && (rsp_bank_reg == SW'(gi))),
                .dout       (bank_dout[gi]),
                .bank_act   (bank_act_vec[gi]),
                .bank_sleep (bank_sleep[gi])
            );
        end
    endgenerate

    // Response tracking: one outstanding response, held until rsp_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_reg  <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_read_reg  <= 1'b0;
            rsp_bank_reg  <= '0;
        end else begin
            ready_en_reg <= 1'b1;
            if (cmd_acc) begin
                rsp_valid_reg <= 1'b1;
                rsp_read_reg  <= !cmd_we;
                rsp_bank_reg  <= cmd_bank;
            end else if (rsp_ready) begin
                rsp_valid_reg <= 1'b0;
            end
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = (rsp_valid_reg && rsp_read_reg) ? bank_dout[rsp_bank_reg] : '0;

endmodule

// File: tb/tb_n101_ilm_bank_ram.sv
// Bench for the banked ILM RAM: a timestamp-based power model plus a word
// memory predict every output each cycle; directed cases pin key values.
`timescale 1ns/1ps
module tb_n101_ilm_bank_ram;

    localparam int DW    = 32;
    localparam int MW    = 4;
    localparam int AW    = 14;
    localparam int BANKS = 2;
    localparam int IDLE  = 16;
    localparam int WLS   = 1;
    localparam int WSD   = 4;

    localparam int M_AWAKE  = 0;
    localparam int M_LS     = 1;
    localparam int M_SD     = 2;
    localparam int M_WAKING = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_we;
    logic [AW-1:0]    cmd_addr;
    logic [MW-1:0]    cmd_wem;
    logic [DW-1:0]    cmd_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [DW-1:0]    rsp_rdata;
    logic             sd_req;
    logic [BANKS-1:0] bank_sleep;

    int checks = 0;
    int errors = 0;

    n101_ilm_bank_ram #(
        .DW(DW), .MW(MW), .AW(AW), .BANKS(BANKS),
        .IDLE_CYC(IDLE), .WAKE_LS(WLS), .WAKE_SD(WSD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_addr   (cmd_addr),
        .cmd_wem    (cmd_wem),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .sd_req     (sd_req),
        .bank_sleep (bank_sleep)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int              mode [BANKS];
    longint          act_start [BANKS];
    longint          wake_done [BANKS];
    longint          cyc = 0;
    bit              m_rsp_v = 0;
    int              m_rsp_bank = 0;
    logic [DW-1:0]   m_rsp_d = '0;
    bit              m_ready_en = 0;
    logic [DW-1:0]   mmem [int];

    always @(negedge clk) begin
        int            tgt;
        int            a;
        bit            exp_ready;
        bit            acc;
        bit            busy;
        bit            hit;
        logic [BANKS-1:0] exp_sleep;
        logic [DW-1:0] w;
        if (!rst_n) begin
            check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
            check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
            check("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
            check("rst_bank_sleep", {62'd0, bank_sleep}, 64'd0);
            for (int b = 0; b < BANKS; b++) begin
                mode[b]      = M_AWAKE;
                act_start[b] = cyc;
            end
            m_rsp_v    = 0;
            m_ready_en = 0;
        end else begin
            a   = int'(cmd_addr);
            tgt = a % BANKS;
            exp_ready = m_ready_en && (mode[tgt] == M_AWAKE) && !sd_req && !(m_rsp_v && !rsp_ready);
            for (int b = 0; b < BANKS; b++)
                exp_sleep[b] = (mode[b] == M_LS) || (mode[b] == M_SD);
            check("cmd_ready", {63'd0, cmd_ready}, {63'd0, exp_ready});
            check("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_rsp_v});
            if (m_rsp_v)
                check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, m_rsp_d});
            check("bank_sleep", {62'd0, bank_sleep}, {62'd0, exp_sleep});

            acc = cmd_valid && exp_ready;
            for (int b = 0; b < BANKS; b++) begin
                busy = m_rsp_v && (m_rsp_bank == b);
                hit  = cmd_valid && (tgt == b);
                case (mode[b])
                    M_AWAKE: begin
                        if (sd_req && !busy) mode[b] = M_SD;
                        else if (acc && hit) act_start[b] = cyc + 1;
                        else if (IDLE > 0 && (cyc - act_start[b]) >= IDLE && !busy) mode[b] = M_LS;
                    end
                    M_LS: begin
                        if (sd_req) mode[b] = M_SD;
                        else if (hit) begin
                            mode[b] = M_WAKING;
                            wake_done[b] = cyc + 1 + WLS;
                        end
                    end
                    M_SD: begin
                        if (!sd_req) begin
                            mode[b] = M_WAKING;
                            wake_done[b] = cyc + 1 + WSD;
                        end
                    end
                    default: begin
                        if (sd_req) mode[b] = M_SD;
                        else if (cyc + 1 >= wake_done[b]) begin
                            mode[b] = M_AWAKE;
                            act_start[b] = cyc + 1;
                        end
                    end
                endcase
            end

            if (acc) begin
                m_rsp_v    = 1;
                m_rsp_bank = tgt;
                if (cmd_we) begin
                    m_rsp_d = '0;
                    w = mmem.exists(a) ? mmem[a] : '0;
                    for (int i = 0; i < MW; i++)
                        if (cmd_wem[i]) w[i*8 +: 8] = cmd_wdata[i*8 +: 8];
                    mmem[a] = w;
                end else begin
                    m_rsp_d = mmem.exists(a) ? mmem[a] : 'x;
                end
            end else if (rsp_ready) begin
                m_rsp_v = 0;
            end
            m_ready_en = 1;
            cyc++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic we, input logic [AW-1:0] a, input logic [MW-1:0] m,
                          input logic [DW-1:0] d, output int lat);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wem   = m;
        cmd_wdata = d;
        lat = 0;
        @(negedge clk);
        while (!cmd_ready && lat < 60) begin
            lat++;
            @(negedge clk);
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept_timeout actual=no_accept required=accept addr=%0h", a);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [DW-1:0] d, output int w);
        w = 0;
        @(negedge clk);
        while (!rsp_valid && w < 60) begin
            w++;
            @(negedge clk);
        end
        if (!rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout actual=no_rsp required=rsp");
        end
        d = rsp_rdata;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        int lat, w, kind, n;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0;
        cmd_wem = '0; cmd_wdata = '0; rsp_ready = 1'b1; sd_req = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // fill the address pool used by all later traffic
        for (int i = 0; i < 16; i++) begin
            do_cmd(1'b1, AW'(i), 4'hF, $urandom, lat);
            get_rsp(d, w);
        end

        // full write / read back on bank 1
        do_cmd(1'b1, 14'h0005, 4'hF, 32'hA5A5_1234, lat);
        get_rsp(d, w);
        check("t1_write_rdata", {32'd0, d}, 64'd0);
        do_cmd(1'b0, 14'h0005, 4'h0, 32'h0, lat);
        get_rsp(d, w);
        check("t1_rsp_latency", 64'(w), 64'd0);
        check("t1_rdata", {32'd0, d}, 64'hA5A5_1234);

        // partial writes, including an empty mask
        do_cmd(1'b1, 14'h0003, 4'hF, 32'h1122_3344, lat);
        get_rsp(d, w);
        do_cmd(1'b1, 14'h0003, 4'h2, 32'hFFFF_AAFF, lat);
        get_rsp(d, w);
        do_cmd(1'b1, 14'h0003, 4'h0, 32'hDEAD_BEEF, lat);
        get_rsp(d, w);
        check("t2_nomask_rdata", {32'd0, d}, 64'd0);
        do_cmd(1'b0, 14'h0003, 4'h0, 32'h0, lat);
        get_rsp(d, w);
        check("t2_partial_rdata", {32'd0, d}, 64'h1122_AA44);

        // idle into light sleep, wake bank 0 only
        repeat (20) step();
        check("t3_sleep_all", {62'd0, bank_sleep}, 64'h3);
        do_cmd(1'b0, 14'h0000, 4'h0, 32'h0, lat);
        check("t3_ls_wake_lat", 64'(lat), 64'(WLS + 1));
        get_rsp(d, w);
        check("t3_sleep_b1", {62'd0, bank_sleep}, 64'h2);

        // shutdown with a command waiting, then wake on the fall
        sd_req = 1'b1;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 14'h0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_ready_in_sd", {63'd0, cmd_ready}, 64'd0);
            step();
        end
        check("t4_sleep_sd", {62'd0, bank_sleep}, 64'h3);
        sd_req = 1'b0;
        do_cmd(1'b0, 14'h0003, 4'h0, 32'h0, lat);
        check("t4_sd_wake_lat", 64'(lat), 64'(WSD + 1));
        get_rsp(d, w);
        check("t4_sd_rdata", {32'd0, d}, 64'h1122_AA44);

        // stalled response
        rsp_ready = 1'b0;
        do_cmd(1'b0, 14'h0005, 4'h0, 32'h0, lat);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 14'h0003;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_stall_valid", {63'd0, rsp_valid}, 64'd1);
            check("t5_stall_rdata", {32'd0, rsp_rdata}, 64'hA5A5_1234);
            check("t5_stall_ready", {63'd0, cmd_ready}, 64'd0);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t5_release_ready", {63'd0, cmd_ready}, 64'd1);
        step();
        cmd_valid = 1'b0;
        @(negedge clk);
        check("t5_next_rdata", {32'd0, rsp_rdata}, 64'h1122_AA44);
        step();

        // reset in the middle of a wake and of a stalled response
        repeat (20) step();
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 14'h0000;
        step();
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check("t6_wake_rst_sleep", {62'd0, bank_sleep}, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        rsp_ready = 1'b0;
        do_cmd(1'b0, 14'h0005, 4'h0, 32'h0, lat);
        rst_n = 1'b0;
        #1;
        check("t6_rsp_rst_valid", {63'd0, rsp_valid}, 64'd0);
        step();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        step();
        do_cmd(1'b0, 14'h0005, 4'h0, 32'h0, lat);
        check("t6_resume_lat", 64'(lat), 64'd0);
        get_rsp(d, w);
        check("t6_resume_rdata", {32'd0, d}, 64'hA5A5_1234);

        // randomized traffic against the model
        for (int blk = 0; blk < 40; blk++) begin
            kind = $urandom_range(0, 5);
            n = (kind == 0) ? 20 : (kind == 1) ? $urandom_range(3, 10) : 15;
            sd_req = (kind == 1);
            for (int i = 0; i < n; i++) begin
                cmd_valid = (kind != 0) && ($urandom_range(0, 3) != 0);
                cmd_we    = $urandom_range(0, 1);
                cmd_addr  = AW'($urandom_range(0, 15));
                cmd_wem   = MW'($urandom);
                cmd_wdata = $urandom;
                rsp_ready = ($urandom_range(0, 3) != 0);
                step();
            end
        end
        sd_req = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
